// File: rtl/computie_bus_pkg.sv
// Shared types for the bus sequencer: FSM states, transceiver direction
// constants and the state-to-control decode used for registered outputs.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_REQ, S_ACK, S_ERR
  } state_t;

  localparam logic DIR_TO_BUS   = 1'b1;
  localparam logic DIR_FROM_BUS = 1'b0;

  typedef struct packed {
    logic addr_oe;
    logic data_oe;
    logic dtack;
    logic berr;
    logic req_valid;
  } ctl_t;

  // Control levels for the cycle spent in state s (wr = transfer is a write).
  function automatic ctl_t ctl_for(state_t s, logic wr);
    ctl_t c;
    c = '0;
    case (s)
      S_ADDR:  c.addr_oe   = 1'b1;
      S_WDATA: c.data_oe   = 1'b1;
      S_REQ:   c.req_valid = 1'b1;
      S_ACK:   begin c.dtack = 1'b1; c.data_oe = ~wr; end
      S_ERR:   c.berr      = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic dir_for(state_t s, logic wr);
    return ((s == S_REQ || s == S_ACK) && !wr) ? DIR_TO_BUS : DIR_FROM_BUS;
  endfunction

endpackage

// File: rtl/computie_bus_sync.sv
// Two-flop synchroniser for asynchronous bus strobes.
module computie_bus_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/computie_bus_sequencer.sv
// Sequences a multiplexed async bus cycle (address, optional write data,
// core request, acknowledge/error) into a simple core request interface.
module computie_bus_sequencer
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH   = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int ADDR_SETUP = 1,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_as,
  input  logic                  bus_rw,
  input  logic [BITWIDTH-1:0]   from_bus,
  output logic [BITWIDTH-1:0]   to_bus,
  output logic                  addr_oe,
  output logic                  data_oe,
  output logic                  data_dir,
  output logic                  dtack,
  output logic                  berr,
  output logic                  req_valid,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [BITWIDTH-1:0]   req_wdata,
  input  logic                  req_ready,
  input  logic [BITWIDTH-1:0]   rsp_rdata
);

  localparam int CNT_MAX = (WAIT_MAX > ADDR_SETUP) ? WAIT_MAX : ADDR_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             as_s, rw_s;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             nxt_write;
  ctl_t             ctl;

  computie_bus_sync #(.WIDTH(1)) u_sync_as (.clk(clk), .reset(reset), .d(bus_as), .q(as_s));
  computie_bus_sync #(.WIDTH(1)) u_sync_rw (.clk(clk), .reset(reset), .d(bus_rw), .q(rw_s));

  // Dropping the strobe before the core answers abandons the cycle silently.
  always_comb begin
    nxt       = state;
    nxt_write = req_write;
    unique case (state)
      S_IDLE:  if (as_s) nxt = S_ADDR;
      S_ADDR: begin
        if (!as_s) nxt = S_IDLE;
        else if (cnt == CNT_W'(ADDR_SETUP - 1)) begin
          nxt_write = ~rw_s;
          nxt       = rw_s ? S_REQ : S_WDATA;
        end
      end
      S_WDATA: nxt = as_s ? S_REQ : S_IDLE;
      S_REQ: begin
        if (!as_s)                               nxt = S_IDLE;
        else if (req_ready)                      nxt = S_ACK;
        else if (cnt == CNT_W'(WAIT_MAX - 1))    nxt = S_ERR;
      end
      S_ACK, S_ERR: if (!as_s) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    ctl = ctl_for(nxt, nxt_write);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_oe   <= 1'b0;
      data_oe   <= 1'b0;
      data_dir  <= DIR_FROM_BUS;
      dtack     <= 1'b0;
      berr      <= 1'b0;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      to_bus    <= '0;
    end else begin
      state     <= nxt;
      addr_oe   <= ctl.addr_oe;
      data_oe   <= ctl.data_oe;
      dtack     <= ctl.dtack;
      berr      <= ctl.berr;
      req_valid <= ctl.req_valid;
      // Direction only flips while the data transceiver is off on both sides.
      if (!data_oe && !ctl.data_oe) data_dir <= dir_for(nxt, nxt_write);
      if (nxt != state) cnt <= '0;
      else if (state == S_ADDR || state == S_REQ) cnt <= cnt + CNT_W'(1);
      if (state == S_ADDR && (nxt == S_REQ || nxt == S_WDATA)) begin
        req_addr  <= from_bus[ADDR_WIDTH-1:0];
        req_write <= nxt_write;
      end
      if (state == S_WDATA && nxt == S_REQ) req_wdata <= from_bus;
      if (state == S_REQ && nxt == S_ACK && !req_write) to_bus <= rsp_rdata;
    end
  end

endmodule

// File: doc/computie_bus_sequencer.md
COMPUTIE_BUS_SEQUENCER -- requirements
Module: computie_bus_sequencer

Interface
REQ-001 Parameter BITWIDTH, default 32, SHALL set the width of the shared bus and data paths.
REQ-002 Parameter ADDR_WIDTH, default 24, SHALL set the latched address width, and SHALL be <= BITWIDTH.
REQ-003 Parameter ADDR_SETUP, default 1, SHALL set the ADDR state duration in cycles, and SHALL be >= 1.
REQ-004 Parameter WAIT_MAX, default 15, SHALL set the cycles in REQ before a bus error, and SHALL be >= 1.
REQ-005 Port clk, input, 1: the single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port bus_as, input, 1: asynchronous active-high address strobe from the bus master.
REQ-008 Port bus_rw, input, 1: 1 = bus reads from FPGA; 0 = bus writes to FPGA.
REQ-009 Port from_bus, input, BITWIDTH: shared multiplexed address/data sample.
REQ-010 Port to_bus, output, BITWIDTH: read data driven toward the bus.
REQ-011 Port addr_oe, output, 1: address transceiver enable.
REQ-012 Port data_oe, output, 1: data transceiver enable.
REQ-013 Port data_dir, output, 1: 1 = FPGA drives the bus.
REQ-014 Port dtack, output, 1: transfer acknowledge.
REQ-015 Port berr, output, 1: bus error.
REQ-016 Ports req_valid (out, 1), req_write (out, 1), req_addr (out, ADDR_WIDTH) and req_wdata (out, BITWIDTH) SHALL form the core request.
REQ-017 Ports req_ready (in, 1) and rsp_rdata (in, BITWIDTH) SHALL form the core response.

Function
REQ-018 bus_as and bus_rw SHALL pass through two-flop synchronisers; as_s and rw_s denote the second-flop outputs.
REQ-019 States: IDLE, ADDR, WDATA, REQ, ACK, ERR.
REQ-020 IDLE: all enables, dtack, berr and req_valid are 0; on an edge with as_s=1 -> ADDR.
REQ-021 ADDR: addr_oe=1 and data_oe=0 for exactly ADDR_SETUP cycles.
- On the final ADDR edge: req_addr <= from_bus[ADDR_WIDTH-1:0] and req_write <= ~rw_s.
- Then -> WDATA if write, else -> REQ.
REQ-022 WDATA: addr_oe=0, data_dir=0, data_oe=1 for one cycle; on exit req_wdata <= from_bus; -> REQ.
REQ-023 REQ: req_valid=1 with req_addr, req_write and req_wdata stable; for reads, data_dir=1 with data_oe=0.
REQ-024 REQ, on an edge with req_ready=1: to_bus <= rsp_rdata (reads only); -> ACK.
REQ-025 ACK: dtack=1, req_valid=0; data_oe=1 for reads, 0 for writes; held until as_s=0, then -> IDLE.
REQ-026 The wait counter SHALL clear on REQ entry and increment each REQ cycle.
- When it reaches WAIT_MAX without req_ready -> ERR.
- req_ready on the same edge as the timeout SHALL win (-> ACK).
REQ-027 ERR: berr=1, all enables 0, req_valid=0; held until as_s=0, then -> IDLE.
REQ-028 as_s=0 in ADDR, WDATA or REQ SHALL abort to IDLE: req_valid drops, and no dtack or berr is issued.
REQ-029 data_dir SHALL change only on edges where data_oe is 0 both before and after the edge (no transceiver contention).
REQ-030 addr_oe and data_oe SHALL never be 1 in the same cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While reset=1: state=IDLE, and all outputs, synchronisers and the counter are 0, asynchronously and without waiting for clk.
REQ-033 Reset asserted mid-transfer SHALL drop dtack, berr, req_valid and all enables immediately.
REQ-034 After reset release, a transfer SHALL start only on a fresh as_s=1 sample.

Structure
REQ-035 Package computie_bus_pkg SHALL hold the state enum and the DIR_TO_BUS/DIR_FROM_BUS constants.
REQ-036 Sub-module computie_bus_sync SHALL be the parametrised two-flop synchroniser, instanced for bus_as and bus_rw.

Verification
REQ-037 Read, defaults: bus_as rises, bus_rw=1, from_bus=0x00123456, req_ready held 1, rsp_rdata=0xCAFEF00D -> req_addr=0x123456, dtack=1 five edges after bus_as is first sampled, to_bus=0xCAFEF00D, data_oe=1, data_dir=1.
REQ-038 Write: bus_rw=0, address 0x000100 then data 0xDEADBEEF -> req_write=1, req_wdata=0xDEADBEEF, dtack six edges after bus_as, data_dir=0 throughout.
REQ-039 Timeout: req_ready held 0 -> berr=1 after exactly 15 REQ cycles, dtack never asserts, IDLE after bus_as falls.
REQ-040 Timeout tie: req_ready=1 exactly on the 15th REQ cycle -> dtack=1 and berr stays 0.
REQ-041 Abort: bus_as falls during REQ -> req_valid=0 within 3 edges, no dtack or berr, next transfer completes normally.
REQ-042 Reset pulse during ACK -> all outputs 0 in the same cycle; assertion checks of REQ-029 and REQ-030 run on every cycle.
